// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit: funct3 codes, BHT constants,
// the registered result flag bundle and the BHT counter update helper.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] BHT_INIT = 2'b01;

  // Registered per-result flags held alongside the registered target
  typedef struct packed {
    logic taken;
    logic illegal;
    logic mispredict;
  } result_flags_t;

  // Two-bit saturating counter step toward the resolved direction
  function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != 2'b11) nxt = cnt + 2'b01;
    end else begin
      if (cnt != 2'b00) nxt = cnt - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational RV branch condition evaluator on full operands.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            taken,
  output logic            illegal
);

  // Select the condition; reserved encodings are flagged illegal and never taken
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1_data == rs2_data);
      F3_BNE:  taken = (rs1_data != rs2_data);
      F3_BLT:  taken = ($signed(rs1_data) <  $signed(rs2_data));
      F3_BGE:  taken = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: taken = (rs1_data <  rs2_data);
      F3_BGEU: taken = (rs1_data >= rs2_data);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates the branch condition, computes the next PC and
// registers the result behind a valid/ready handshake with statistics counters.
// Optional branch history table enabled by defining BRANCH_PRED_EN.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned BHT_IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             BRANCH,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             TAKEN,
  output logic [XLEN-1:0]  TARGET,
  output logic             ILLEGAL,
  output logic             MISPREDICT,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
`ifdef BRANCH_PRED_EN
  ,
  output logic             bht_pred
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic            cmp_taken;
  logic            cmp_illegal;
  logic            accept_c;
  logic            valid_branch_c;
  logic [XLEN-1:0] target_c;
  result_flags_t   res_c;
  result_flags_t   res_q;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .taken    (cmp_taken),
    .illegal  (cmp_illegal)
  );

  assign in_ready       = !out_valid || out_ready;
  assign accept_c       = in_valid && in_ready && !flush;
  assign valid_branch_c = BRANCH && !cmp_illegal;

  // Resolve the request; non-branches fall through to pc+4
  always_comb begin
    res_c            = '0;
    res_c.taken      = BRANCH && cmp_taken;
    res_c.illegal    = BRANCH && cmp_illegal;
`ifdef BRANCH_PRED_EN
    res_c.mispredict = res_c.taken != pred_taken;
`endif
    target_c = pc + (res_c.taken ? imm : XLEN'(4));
  end

  // Output register: flush wins over both accept and consumer handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res_q     <= '0;
      TARGET    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept_c) begin
      out_valid <= 1'b1;
      res_q     <= res_c;
      TARGET    <= target_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign TAKEN      = res_q.taken;
  assign ILLEGAL    = res_q.illegal;
  assign MISPREDICT = res_q.mispredict;

  // Saturating statistics, counted at accept time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (accept_c) begin
      if (valid_branch_c && branch_cnt != CNT_MAX) branch_cnt <= branch_cnt + CNT_W'(1);
      if (res_c.taken && taken_cnt != CNT_MAX)     taken_cnt  <= taken_cnt + CNT_W'(1);
    end
  end

`ifdef BRANCH_PRED_EN
  localparam int unsigned BHT_N = 1 << BHT_IDX_W;

  logic [1:0]           bht [BHT_N];
  logic [BHT_IDX_W-1:0] bht_idx_c;

  assign bht_idx_c = pc[BHT_IDX_W+1:2];
  assign bht_pred  = bht[bht_idx_c][1];

  // History table trained on every accepted legal branch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= BHT_INIT;
    end else if (accept_c && valid_branch_c) begin
      bht[bht_idx_c] <= bht_next(bht[bht_idx_c], res_c.taken);
    end
  end
`else
  logic unused_pred;
  assign unused_pred = ^{pred_taken, pc[BHT_IDX_W+1:2]};
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed scoreboard bench for branch_resolve_unit (XLEN=32, 4-bit counters).
module tb_branch_resolve_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             BRANCH;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  imm;
  logic             pred_taken;
  logic             out_valid;
  logic             out_ready;
  logic             TAKEN;
  logic [XLEN-1:0]  TARGET;
  logic             ILLEGAL;
  logic             MISPREDICT;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;
`ifdef BRANCH_PRED_EN
  logic             bht_pred;
`endif

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W), .BHT_IDX_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .BRANCH     (BRANCH),
    .funct3     (funct3),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .pc         (pc),
    .imm        (imm),
    .pred_taken (pred_taken),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .TAKEN      (TAKEN),
    .TARGET     (TARGET),
    .ILLEGAL    (ILLEGAL),
    .MISPREDICT (MISPREDICT),
    .branch_cnt (branch_cnt),
    .taken_cnt  (taken_cnt)
`ifdef BRANCH_PRED_EN
    ,
    .bht_pred   (bht_pred)
`endif
  );

  typedef struct {
    logic        taken;
    logic        illegal;
    logic        mispredict;
    logic [31:0] target;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   bc_exp   = 0;
  int   tc_exp   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output handshake pops and checks one expected result
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'(out_valid), 64'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("taken",      64'(TAKEN),      64'(e.taken));
        chk("illegal",    64'(ILLEGAL),    64'(e.illegal));
        chk("mispredict", 64'(MISPREDICT), 64'(e.mispredict));
        chk("target",     64'(TARGET),     64'(e.target));
      end
    end
  end

  // Drive one request, wait for acceptance and log its hand-computed result
  task automatic issue(input logic br, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] p, input logic [31:0] im,
                       input logic pt, input logic e_taken, input logic e_ill,
                       input logic [31:0] e_tgt);
    exp_t e;
    int   n;
    BRANCH = br; funct3 = f3; rs1_data = a; rs2_data = b;
    pc = p; imm = im; pred_taken = pt; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk("accept_timeout", 64'(in_ready), 64'(1));
      in_valid = 1'b0;
      return;
    end
    e.taken   = e_taken;
    e.illegal = e_ill;
`ifdef BRANCH_PRED_EN
    e.mispredict = e_taken != pt;
`else
    e.mispredict = 1'b0;
`endif
    e.target = e_tgt;
    exp_q.push_back(e);
    if (br && !e_ill && bc_exp < 15) bc_exp++;
    if (e_taken && tc_exp < 15) tc_exp++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_queue_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_branch_cnt"}, 64'(branch_cnt), 64'(bc_exp));
    chk({tag, "_taken_cnt"},  64'(taken_cnt),  64'(tc_exp));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    BRANCH = 1'b0; funct3 = 3'b000; rs1_data = '0; rs2_data = '0;
    pc = '0; imm = '0; pred_taken = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid",  64'(out_valid),  64'(0));
    chk("rst_taken",      64'(TAKEN),      64'(0));
    chk("rst_target",     64'(TARGET),     64'(0));
    chk("rst_illegal",    64'(ILLEGAL),    64'(0));
    chk("rst_mispredict", 64'(MISPREDICT), 64'(0));
    chk("rst_in_ready",   64'(in_ready),   64'(1));
    chk_cnt("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Condition vectors (pc=0x100, imm=0x20 unless noted)
    issue(1'b1, 3'b000, 32'h1234, 32'h1234, 32'h100, 32'h20, 1'b1, 1'b1, 1'b0, 32'h120);
    issue(1'b1, 3'b001, 32'h1234, 32'h1234, 32'h100, 32'h20, 1'b1, 1'b0, 1'b0, 32'h104);
    issue(1'b1, 3'b100, 32'hFFFFFFFF, 32'h1, 32'h100, 32'h20, 1'b0, 1'b1, 1'b0, 32'h120);
    issue(1'b1, 3'b110, 32'hFFFFFFFF, 32'h1, 32'h100, 32'h20, 1'b0, 1'b0, 1'b0, 32'h104);
    issue(1'b1, 3'b101, 32'hFFFFFFFF, 32'h1, 32'h100, 32'h20, 1'b1, 1'b0, 1'b0, 32'h104);
    issue(1'b1, 3'b111, 32'hFFFFFFFF, 32'h1, 32'h100, 32'h20, 1'b1, 1'b1, 1'b0, 32'h120);
    issue(1'b1, 3'b010, 32'h5, 32'h5, 32'h100, 32'h20, 1'b0, 1'b0, 1'b1, 32'h104);
    issue(1'b1, 3'b011, 32'h5, 32'h6, 32'h100, 32'h20, 1'b1, 1'b0, 1'b1, 32'h104);
    issue(1'b0, 3'b000, 32'h7, 32'h7, 32'h100, 32'h20, 1'b0, 1'b0, 1'b0, 32'h104);
    issue(1'b1, 3'b000, 32'h0, 32'h0, 32'hFFFFFFF0, 32'h20, 1'b1, 1'b1, 1'b0, 32'h10);
    issue(1'b0, 3'b001, 32'h0, 32'h1, 32'hFFFFFFFC, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0);
    drain();
    chk_cnt("vectors");

    // Backpressure: result A held, request B stalled until the consumer is ready
    out_ready = 1'b0;
    issue(1'b1, 3'b000, 32'h9, 32'h9, 32'h200, 32'hFFFFFFF8, 1'b1, 1'b1, 1'b0, 32'h1F8);
    BRANCH = 1'b1; funct3 = 3'b001; rs1_data = 32'h5; rs2_data = 32'h6;
    pc = 32'h300; imm = 32'h10; pred_taken = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready",  64'(in_ready),  64'(0));
      chk("bp_out_valid", 64'(out_valid), 64'(1));
      chk("bp_target",    64'(TARGET),    64'(32'h1F8));
      chk("bp_taken",     64'(TAKEN),     64'(1));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    exp_q.push_back('{taken: 1'b1, illegal: 1'b0, mispredict: 1'b0, target: 32'h310});
    if (bc_exp < 15) bc_exp++;
    if (tc_exp < 15) tc_exp++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();
    chk_cnt("bp");

    // Flush together with an accept: nothing presented, counters untouched
    BRANCH = 1'b1; funct3 = 3'b000; rs1_data = 32'h1; rs2_data = 32'h1;
    pc = 32'h100; imm = 32'h20; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk_cnt("flush");
    @(posedge clk);
    #1;
    chk("flush_out_valid2", 64'(out_valid), 64'(0));

    // Saturation of both counters at all-ones
    for (int i = 0; i < 10; i++)
      issue(1'b1, 3'b000, 32'h3, 32'h3, 32'h100, 32'h20, 1'b1, 1'b1, 1'b0, 32'h120);
    drain();
    chk_cnt("sat");
    chk("sat_branch_allones", 64'(branch_cnt), 64'(15));
    chk("sat_taken_allones",  64'(taken_cnt),  64'(15));

    // Asynchronous reset while a result is held
    out_ready = 1'b0;
    issue(1'b1, 3'b000, 32'h3, 32'h3, 32'h100, 32'h20, 1'b1, 1'b1, 1'b0, 32'h120);
    chk("hold_out_valid", 64'(out_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'(0));
    chk("async_rst_target",    64'(TARGET),    64'(0));
    exp_q.delete();
    bc_exp = 0;
    tc_exp = 0;
    chk_cnt("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

`ifdef BRANCH_PRED_EN
    // BHT training at one pc: 01 -> 10 -> 11 (saturates), then back down
    pc = 32'h404;
    #1;
    chk("bht_pred_init", 64'(bht_pred), 64'(0));
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 3'b000, 32'h1, 32'h1, 32'h404, 32'h8, 1'b0, 1'b1, 1'b0, 32'h40C);
      chk("bht_pred_taken", 64'(bht_pred), 64'(1));
    end
    issue(1'b1, 3'b001, 32'h1, 32'h1, 32'h404, 32'h8, 1'b0, 1'b0, 1'b0, 32'h408);
    chk("bht_pred_nt1", 64'(bht_pred), 64'(1));
    issue(1'b1, 3'b001, 32'h1, 32'h1, 32'h404, 32'h8, 1'b0, 1'b0, 1'b0, 32'h408);
    chk("bht_pred_nt2", 64'(bht_pred), 64'(0));
    drain();
`endif

    // Post-reset traffic still flows and counts from zero
    issue(1'b1, 3'b110, 32'h1, 32'h2, 32'h500, 32'h40, 1'b1, 1'b1, 1'b0, 32'h540);
    drain();
    chk_cnt("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Parametrised successor to the two-flag BEQ/BNE branch decoder. It resolves all six RV branch conditions on full operands rather than an ALU ZERO flag, computes the branch target, and registers the result behind a valid/ready handshake. It sits between the EX operand stage and the PC-select / pipeline-flush logic and keeps branch statistics counters.

Parameters:
XLEN, 32, operand, PC and target width (32 or 64)
CNT_W, 32, width of the statistics counters
BHT_IDX_W, 4, BHT index bits; the table has 2^BHT_IDX_W entries (used only with BRANCH_PRED_EN)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of the held result and of any accept in the same cycle
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request
BRANCH  input  1  instruction is a conditional branch
funct3  input  3  branch condition
rs1_data  input  XLEN  operand 1
rs2_data  input  XLEN  operand 2
pc  input  XLEN  instruction PC
imm  input  XLEN  sign-extended B-immediate
pred_taken  input  1  front-end prediction (used only with BRANCH_PRED_EN)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
TAKEN  output  1  branch resolved taken
TARGET  output  XLEN  next PC: pc+imm if TAKEN, otherwise pc+4
ILLEGAL  output  1  BRANCH=1 with funct3 010 or 011
MISPREDICT  output  1  TAKEN != pred_taken (0 when BRANCH_PRED_EN is undefined)
branch_cnt  output  CNT_W  resolved branches
taken_cnt  output  CNT_W  resolved taken branches

Behaviour:
- Reset (async, rst_n=0): out_valid=0, TAKEN=0, TARGET=0, ILLEGAL=0, MISPREDICT=0, both counters=0, all BHT entries=2'b01. No output is ever X; BRANCH=0 produces defined outputs.
- in_ready = !out_valid || out_ready. A request is accepted when in_valid && in_ready && !flush.
- Latency is 1 cycle: an accept at edge N gives out_valid=1 after edge N with the registered result. Back-to-back throughput is 1 per cycle when out_ready=1.
- Result fields hold stable while out_valid && !out_ready.
- Conditions when BRANCH=1:
  - 000 BEQ: taken if a==b
  - 001 BNE: taken if a!=b
  - 100 BLT: signed a<b
  - 101 BGE: signed a>=b
  - 110 BLTU: unsigned a<b
  - 111 BGEU: unsigned a>=b
  - 010/011: TAKEN=0, ILLEGAL=1
- BRANCH=0: TAKEN=0, ILLEGAL=0, TARGET=pc+4, counters unchanged.
- TARGET arithmetic is modulo 2^XLEN; wrap-around is silent.
- Counters increment on accept, not on output handshake:
  - branch_cnt on accept with BRANCH=1 && !ILLEGAL
  - taken_cnt on accept with TAKEN
  - both saturate at all-ones and never wrap
- flush=1: out_valid clears at the next edge and any same-cycle accept is dropped, including its counter and BHT update. flush has priority over out_ready. in_ready is not gated by flush.
- Reset asserted mid-transaction discards the held result immediately (asynchronous clear).

Optional Feature:
- Macro: BRANCH_PRED_EN.
- Defined:
  - Instantiates a 2^BHT_IDX_W-entry table of 2-bit saturating counters indexed by pc[BHT_IDX_W+1:2].
  - On each valid branch accept, the entry increments if taken and decrements if not, saturating at 00 and 11.
  - MISPREDICT = registered (TAKEN != pred_taken).
  - Adds output bht_pred (1 bit, combinational MSB of the entry indexed by the current pc) for the front end.
- Undefined: no table, no bht_pred port, MISPREDICT tied 0, and pred_taken is ignored.

Decomposition:
- Package branch_pkg holds:
  - funct3 localparams F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU
  - BHT counter constant BHT_INIT=2'b01
  - a typedef for the registered result bundle
- One sub-module, branch_cmp: purely combinational, XLEN-parametrised; takes funct3, rs1_data, rs2_data and returns taken and illegal.
- Handshake register, counters and BHT live in the top level.

Test Plan:
- BEQ/BNE, XLEN=32: a=b=0x1234, pc=0x100, imm=0x20. Accept -> next cycle out_valid=1, TAKEN=1, TARGET=0x120 for BEQ; TAKEN=0, TARGET=0x104 for BNE.
- Signed vs unsigned: a=0xFFFFFFFF, b=1. BLT taken, BLTU not taken, BGE not taken, BGEU taken.
- Backpressure: out_ready=0 for 3 cycles after a result. in_ready=0, outputs stable, a second request is held; out_ready=1 -> second result appears the next cycle.
- Illegal and non-branch:
  - funct3=010, BRANCH=1 -> ILLEGAL=1, TAKEN=0, TARGET=pc+4, branch_cnt unchanged.
  - BRANCH=0 -> outputs defined, counters unchanged.
- Flush and reset:
  - flush together with an accept -> out_valid=0 next cycle, counters unchanged.
  - rst_n low mid-hold -> out_valid drops without a clock edge.
  - Counters preloaded to all-ones by forcing stay all-ones after a taken branch.
- BRANCH_PRED_EN: four taken branches at the same pc with pred_taken=0.
  - MISPREDICT=1 each time.
  - bht_pred goes 0→1 after the 1st update (01→10) and stays at 11 after the 2nd.
